// File: rtl/hazard_scoreboard_pkg.sv
// Shared definitions for the D-stage hazard/forwarding unit: default geometry,
// stage codes emitted by the decoder and the mult/div busy latencies.
package hazard_scoreboard_pkg;

    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_STAGE_W = 2;
    localparam int DEF_DEPTH   = 3;
    localparam int DEF_CNT_W   = 4;
    localparam int MD_MULT_LAT = 5;
    localparam int MD_DIV_LAT  = 10;

    typedef enum logic [1:0] {
        STAGE_DECODE  = 2'd0,
        STAGE_EXECUTE = 2'd1,
        STAGE_MEM     = 2'd2,
        STAGE_MAX     = 2'd3
    } stage_e;

    // Width of a forward select able to name positions 0..depth.
    function automatic int sel_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/hazard_port_check.sv
// One read port: finds the youngest in-flight writer of raddr and decides
// between stalling, forwarding from its pipeline register, or reading the GRF.
module hazard_port_check #(
    parameter int ADDR_W  = 5,
    parameter int STAGE_W = 2,
    parameter int DEPTH   = 3,
    parameter int FWD_W   = 2
) (
    input  logic                           d_valid,
    input  logic [ADDR_W-1:0]              raddr,
    input  logic [STAGE_W-1:0]             use_stage,
    input  logic [DEPTH-1:0]               ent_valid,
    input  logic [DEPTH-1:0][ADDR_W-1:0]   ent_waddr,
    input  logic [DEPTH-1:0][STAGE_W-1:0]  ent_wstage,
    output logic                           hazard,
    output logic [FWD_W-1:0]               fwd_sel
);

    localparam logic [STAGE_W-1:0] USE_NONE = {STAGE_W{1'b1}};

    logic               hit_s;
    logic               ready_s;
    logic [STAGE_W:0]   hit_pos_s;
    logic [STAGE_W:0]   hit_ws_s;

    // Priority match: scanning oldest to youngest lets the youngest writer win.
    always_comb begin
        hit_s     = 1'b0;
        hit_pos_s = {(STAGE_W+1){1'b0}};
        hit_ws_s  = {(STAGE_W+1){1'b0}};
        for (int p = DEPTH; p >= 1; p--) begin
            if (ent_valid[p-1] && (ent_waddr[p-1] == raddr) && (raddr != {ADDR_W{1'b0}})) begin
                hit_s     = 1'b1;
                hit_pos_s = (STAGE_W+1)'(p);
                hit_ws_s  = {1'b0, ent_wstage[p-1]};
            end else begin
                hit_s     = hit_s;
            end
        end
    end

    // A not-yet-ready writer stalls only if its result arrives after the operand is needed.
    assign ready_s = hit_s && (hit_pos_s > hit_ws_s);
    assign hazard  = d_valid && (use_stage != USE_NONE) && hit_s && !ready_s &&
                     (hit_ws_s >= (hit_pos_s + {1'b0, use_stage}));
    assign fwd_sel = ready_s ? hit_pos_s[FWD_W-1:0] : {FWD_W{1'b0}};

endmodule

// File: rtl/hazard_scoreboard.sv
// D-stage hazard/forwarding unit: shift scoreboard of in-flight writers plus a
// mult/div busy counter, producing stall and per-port forward selects.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int STAGE_W    = DEF_STAGE_W,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int MULT_LAT   = MD_MULT_LAT,
    parameter int DIV_LAT    = MD_DIV_LAT,
    parameter int CNT_W      = DEF_CNT_W,
    localparam int FWD_W     = sel_width(DEPTH)
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                d_valid,
    input  logic [ADDR_W-1:0]   d_raddr0,
    input  logic [ADDR_W-1:0]   d_raddr1,
    input  logic [STAGE_W-1:0]  d_use0,
    input  logic [STAGE_W-1:0]  d_use1,
    input  logic [ADDR_W-1:0]   d_waddr,
    input  logic [STAGE_W-1:0]  d_wstage,
    input  logic                d_md_start,
    input  logic                d_md_div,
    input  logic                d_md_use,
    input  logic                ext_stall,
    input  logic                flush,
    output logic                stall,
    output logic [FWD_W-1:0]    fwd_sel0,
    output logic [FWD_W-1:0]    fwd_sel1,
    output logic                md_busy
);

    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT);

    // Index p-1 holds scoreboard position p (0 = E stage).
    logic [DEPTH-1:0]               ent_valid_r;
    logic [DEPTH-1:0][ADDR_W-1:0]   ent_waddr_r;
    logic [DEPTH-1:0][STAGE_W-1:0]  ent_wstage_r;
    logic [CNT_W-1:0]               md_cnt_r;

    logic hazard0_s;
    logic hazard1_s;
    logic issue_s;

    hazard_port_check #(
        .ADDR_W(ADDR_W), .STAGE_W(STAGE_W), .DEPTH(DEPTH), .FWD_W(FWD_W)
    ) u_port0 (
        .d_valid(d_valid), .raddr(d_raddr0), .use_stage(d_use0),
        .ent_valid(ent_valid_r), .ent_waddr(ent_waddr_r), .ent_wstage(ent_wstage_r),
        .hazard(hazard0_s), .fwd_sel(fwd_sel0)
    );

    hazard_port_check #(
        .ADDR_W(ADDR_W), .STAGE_W(STAGE_W), .DEPTH(DEPTH), .FWD_W(FWD_W)
    ) u_port1 (
        .d_valid(d_valid), .raddr(d_raddr1), .use_stage(d_use1),
        .ent_valid(ent_valid_r), .ent_waddr(ent_waddr_r), .ent_wstage(ent_wstage_r),
        .hazard(hazard1_s), .fwd_sel(fwd_sel1)
    );

    assign md_busy = (md_cnt_r != {CNT_W{1'b0}});
    assign stall   = hazard0_s || hazard1_s || (d_valid && d_md_use && md_busy);
    assign issue_s = d_valid && !stall;

    // Scoreboard shift: flush kills everything, ext_stall freezes, otherwise advance one stage.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ent_valid_r  <= {DEPTH{1'b0}};
            ent_waddr_r  <= {(DEPTH*ADDR_W){1'b0}};
            ent_wstage_r <= {(DEPTH*STAGE_W){1'b0}};
        end else if (flush) begin
            ent_valid_r  <= {DEPTH{1'b0}};
        end else if (!ext_stall) begin
            for (int p = DEPTH - 1; p > 0; p--) begin
                ent_valid_r[p]  <= ent_valid_r[p-1];
                ent_waddr_r[p]  <= ent_waddr_r[p-1];
                ent_wstage_r[p] <= ent_wstage_r[p-1];
            end
            ent_valid_r[0]  <= issue_s && (d_waddr != {ADDR_W{1'b0}});
            ent_waddr_r[0]  <= d_waddr;
            ent_wstage_r[0] <= d_wstage;
        end
    end

    // HI/LO busy counter: loads on an issued mult/div, counts down to zero otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            md_cnt_r <= {CNT_W{1'b0}};
        end else if (flush) begin
            md_cnt_r <= {CNT_W{1'b0}};
        end else if (!ext_stall) begin
            if (issue_s && d_md_start) begin
                md_cnt_r <= d_md_div ? DIV_LOAD : MULT_LOAD;
            end else if (md_busy) begin
                md_cnt_r <= md_cnt_r - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed pipeline scenarios plus
// random traffic compared against a list-based model of the in-flight writers.
module tb_hazard_scoreboard;

    logic       clk;
    logic       reset_n;
    logic       d_valid;
    logic [4:0] d_raddr0, d_raddr1, d_waddr;
    logic [1:0] d_use0, d_use1, d_wstage;
    logic       d_md_start, d_md_div, d_md_use;
    logic       ext_stall, flush;
    logic       stall, md_busy;
    logic [1:0] fwd_sel0, fwd_sel1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: slot p (1..3) = instruction that is p stages past D.
    int m_valid [1:3];
    int m_waddr [1:3];
    int m_wstage[1:3];
    int m_cnt;
    int exp_stall, exp_f0, exp_f1, exp_busy;

    hazard_scoreboard dut (
        .clk(clk), .reset_n(reset_n), .d_valid(d_valid),
        .d_raddr0(d_raddr0), .d_raddr1(d_raddr1), .d_use0(d_use0), .d_use1(d_use1),
        .d_waddr(d_waddr), .d_wstage(d_wstage), .d_md_start(d_md_start),
        .d_md_div(d_md_div), .d_md_use(d_md_use), .ext_stall(ext_stall), .flush(flush),
        .stall(stall), .fwd_sel0(fwd_sel0), .fwd_sel1(fwd_sel1), .md_busy(md_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 1; p <= 3; p++) begin
            m_valid[p] = 0; m_waddr[p] = 0; m_wstage[p] = 0;
        end
        m_cnt = 0;
    endtask

    // Youngest writer decides: ready (past its producing stage) forwards, else maybe stall.
    task automatic port_ref(input int raddr, input int use_c, output int haz, output int fwd);
        haz = 0;
        fwd = 0;
        for (int p = 1; p <= 3; p++) begin
            if (raddr != 0 && m_valid[p] != 0 && m_waddr[p] == raddr) begin
                if (p > m_wstage[p]) fwd = p;
                else if (d_valid && use_c != 3 && (m_wstage[p] - p) >= use_c) haz = 1;
                break;
            end
        end
    endtask

    task automatic model_outputs();
        int h0, h1;
        port_ref(int'(d_raddr0), int'(d_use0), h0, exp_f0);
        port_ref(int'(d_raddr1), int'(d_use1), h1, exp_f1);
        exp_busy  = (m_cnt > 0) ? 1 : 0;
        exp_stall = (h0 != 0 || h1 != 0 || (d_valid && d_md_use && exp_busy != 0)) ? 1 : 0;
    endtask

    task automatic model_step();
        int issue;
        if (flush) begin
            model_reset();
        end else if (!ext_stall) begin
            issue = (d_valid && exp_stall == 0) ? 1 : 0;
            for (int p = 3; p >= 2; p--) begin
                m_valid[p] = m_valid[p-1]; m_waddr[p] = m_waddr[p-1]; m_wstage[p] = m_wstage[p-1];
            end
            m_valid[1]  = (issue != 0 && d_waddr != 5'd0) ? 1 : 0;
            m_waddr[1]  = int'(d_waddr);
            m_wstage[1] = int'(d_wstage);
            if (issue != 0 && d_md_start) m_cnt = d_md_div ? 10 : 5;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_outputs();
        check_val("stall", {31'd0, stall}, exp_stall);
        check_val("fwd_sel0", {30'd0, fwd_sel0}, exp_f0);
        check_val("fwd_sel1", {30'd0, fwd_sel1}, exp_f1);
        check_val("md_busy", {31'd0, md_busy}, exp_busy);
    endtask

    task automatic advance();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        d_valid = 1'b0; d_raddr0 = 5'd0; d_raddr1 = 5'd0; d_use0 = 2'd3; d_use1 = 2'd3;
        d_waddr = 5'd0; d_wstage = 2'd1; d_md_start = 1'b0; d_md_div = 1'b0;
        d_md_use = 1'b0; ext_stall = 1'b0; flush = 1'b0;
    endtask

    task automatic set_instr(input logic v, input int ra0, input int u0, input int ra1,
                             input int u1, input int wa, input int ws);
        d_valid = v; d_raddr0 = 5'(ra0); d_use0 = 2'(u0); d_raddr1 = 5'(ra1);
        d_use1 = 2'(u1); d_waddr = 5'(wa); d_wstage = 2'(ws);
    endtask

    task automatic md_wait(input logic is_div, input string tag, input int exp_cycles);
        int n;
        idle(); set_instr(1'b1, 0, 3, 0, 3, 0, 1);
        d_md_start = 1'b1; d_md_div = is_div; d_md_use = 1'b1;
        sample(); advance();
        idle(); set_instr(1'b1, 0, 3, 0, 3, 0, 1); d_md_use = 1'b1;
        n = 0;
        for (int i = 0; i < 30; i++) begin
            sample();
            if (stall !== 1'b1) break;
            n++;
            advance();
        end
        advance();
        check_val(tag, n, exp_cycles);
    endtask

    initial begin
        model_reset();
        idle();
        reset_n = 1'b0;
        d_valid = 1'b1; d_md_use = 1'b1;
        sample();
        check_val("rst_stall", {31'd0, stall}, 0);
        #2 reset_n = 1'b1;
        advance();

        // ALU result in E, branch needs it in D.
        idle(); set_instr(1'b1, 0, 3, 0, 3, 1, 1); sample(); advance();
        idle(); set_instr(1'b1, 1, 0, 0, 3, 0, 1);
        sample(); check_val("beq_stall", {31'd0, stall}, 1); advance();
        sample(); check_val("beq_fwd0", {30'd0, fwd_sel0}, 2);
        check_val("beq_go", {31'd0, stall}, 0); advance();

        // Load-use.
        idle(); set_instr(1'b1, 0, 3, 0, 3, 2, 2); sample(); advance();
        idle(); set_instr(1'b1, 2, 1, 0, 3, 3, 1);
        sample(); check_val("lw_stall", {31'd0, stall}, 1); advance();
        sample(); check_val("lw_go", {31'd0, stall}, 0); advance();
        idle(); set_instr(1'b1, 3, 3, 2, 1, 0, 1);
        sample(); check_val("lw_fwd1", {30'd0, fwd_sel1}, 3); advance();

        // Register zero is never tracked.
        idle(); set_instr(1'b1, 0, 3, 0, 3, 0, 1); sample(); advance();
        idle(); set_instr(1'b1, 0, 0, 0, 0, 0, 1);
        sample(); check_val("zero_stall", {31'd0, stall}, 0);
        check_val("zero_fwd0", {30'd0, fwd_sel0}, 0); advance();

        md_wait(1'b1, "div_wait", 10);
        md_wait(1'b0, "mult_wait", 5);

        // Downstream freeze with a load in E.
        idle(); set_instr(1'b1, 0, 3, 0, 3, 2, 2); sample(); advance();
        idle(); set_instr(1'b1, 2, 1, 0, 3, 3, 1); ext_stall = 1'b1;
        repeat (3) begin
            sample(); check_val("es_stall", {31'd0, stall}, 1); advance();
        end
        ext_stall = 1'b0;
        sample(); check_val("es_resume", {31'd0, stall}, 1); advance();
        sample(); check_val("es_done", {31'd0, stall}, 0); advance();

        // Flush with a load in flight and a divide pending.
        idle(); set_instr(1'b1, 0, 3, 0, 3, 2, 2); sample(); advance();
        idle(); set_instr(1'b1, 0, 3, 0, 3, 0, 1);
        d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1; sample(); advance();
        idle(); flush = 1'b1; sample(); advance();
        idle(); set_instr(1'b1, 2, 0, 2, 1, 0, 1); d_md_use = 1'b1;
        sample();
        check_val("fl_stall", {31'd0, stall}, 0);
        check_val("fl_fwd0", {30'd0, fwd_sel0}, 0);
        check_val("fl_busy", {31'd0, md_busy}, 0);
        advance();

        // Asynchronous reset while a divide is pending.
        idle(); set_instr(1'b1, 0, 3, 0, 3, 0, 1);
        d_md_start = 1'b1; d_md_div = 1'b1; d_md_use = 1'b1; sample(); advance();
        idle(); set_instr(1'b1, 0, 3, 0, 3, 0, 1); d_md_use = 1'b1;
        #2 check_val("arst_pre", {31'd0, stall}, 1);
        reset_n = 1'b0;
        #1 check_val("arst_stall", {31'd0, stall}, 0);
        check_val("arst_busy", {31'd0, md_busy}, 0);
        model_reset();
        sample();
        #1 reset_n = 1'b1;
        advance();

        // Random traffic on a small register set to provoke matches.
        for (int i = 0; i < 600; i++) begin
            d_valid    = ($urandom_range(9) < 8);
            d_raddr0   = 5'($urandom_range(3));
            d_raddr1   = 5'($urandom_range(3));
            d_use0     = 2'($urandom_range(3));
            d_use1     = 2'($urandom_range(3));
            d_waddr    = 5'($urandom_range(3));
            d_wstage   = 2'($urandom_range(3));
            d_md_use   = ($urandom_range(4) == 0);
            d_md_start = d_md_use && ($urandom_range(1) == 1);
            d_md_div   = ($urandom_range(1) == 1);
            ext_stall  = ($urandom_range(9) == 0);
            flush      = ($urandom_range(29) == 0);
            sample();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
